// File: rtl/vector_issue_pkg.sv
// ============================================================================
// vector_issue_pkg : uop, exec lane and exec info types shared by issue/exec
// Rev 1.0
// ============================================================================
`default_nettype none

package vector_issue_pkg;

   localparam int VECTOR_REGISTERS   = 32;
   localparam int VECTOR_LANES       = 8;
   localparam int DATA_WIDTH         = 32;
   localparam int VECTOR_TICKET_BITS = 5;
   localparam int REG_BITS           = $clog2(VECTOR_REGISTERS);
   localparam int VL_BITS            = $clog2(VECTOR_LANES + 1);

   typedef struct packed {
      logic [REG_BITS-1:0]           src1;
      logic [REG_BITS-1:0]           src2;
      logic [REG_BITS-1:0]           dst;
      logic                          use_src1;
      logic                          use_src2;
      logic [VECTOR_TICKET_BITS-1:0] ticket;
      logic [5:0]                    funct6;
      logic [2:0]                    funct3;
      logic [VL_BITS-1:0]            vl;
      logic [VECTOR_LANES-1:0]       mask;
      logic                          is_rdc;
      logic                          head_uop;
      logic                          end_uop;
   } to_vector_issue;

   typedef struct packed {
      logic                  valid;
      logic                  mask;
      logic [DATA_WIDTH-1:0] data1;
      logic [DATA_WIDTH-1:0] data2;
   } to_vector_exec;

   typedef struct packed {
      logic [REG_BITS-1:0]           dst;
      logic [VECTOR_TICKET_BITS-1:0] ticket;
      logic [5:0]                    funct6;
      logic [2:0]                    funct3;
      logic [VL_BITS-1:0]            vl;
      logic                          is_rdc;
      logic                          head_uop;
      logic                          end_uop;
   } to_vector_exec_info;

   // A producer satisfies a pending source only when it carries the exact ticket recorded.
   function automatic logic producer_hit(input logic [VECTOR_LANES-1:0]       en,
                                         input logic [REG_BITS-1:0]           addr,
                                         input logic [VECTOR_TICKET_BITS-1:0] tkt,
                                         input logic [REG_BITS-1:0]           src,
                                         input logic [VECTOR_TICKET_BITS-1:0] sb_tkt);
      return (|en) && (addr == src) && (tkt == sb_tkt);
   endfunction

endpackage

`default_nettype wire

// File: rtl/vector_scoreboard.sv
// ============================================================================
// vector_scoreboard : per-register pending bit and producer ticket, two lookups
// Rev 1.0
// ============================================================================
`default_nettype none

module vector_scoreboard
   import vector_issue_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          set_en_i,
   input  logic [REG_BITS-1:0]           set_addr_i,
   input  logic [VECTOR_TICKET_BITS-1:0] set_ticket_i,
   input  logic [VECTOR_LANES-1:0]       wr_en_i,
   input  logic [REG_BITS-1:0]           wr_addr_i,
   input  logic [VECTOR_TICKET_BITS-1:0] wr_ticket_i,
   input  logic [REG_BITS-1:0]           lookup_a_i,
   input  logic [REG_BITS-1:0]           lookup_b_i,
   output logic                          pend_a_o,
   output logic [VECTOR_TICKET_BITS-1:0] ticket_a_o,
   output logic                          pend_b_o,
   output logic [VECTOR_TICKET_BITS-1:0] ticket_b_o,
   output logic                          any_pending_o
);

   logic [VECTOR_REGISTERS-1:0]   r_pending;
   logic [VECTOR_TICKET_BITS-1:0] r_ticket [VECTOR_REGISTERS];
   logic                          w_clr;

   assign w_clr = (|wr_en_i) && r_pending[wr_addr_i] && (r_ticket[wr_addr_i] == wr_ticket_i);

   // The set is written last so it overrides a same-cycle clear of that register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= '0;
         for (int i = 0; i < VECTOR_REGISTERS; i++) r_ticket[i] <= '0;
      end else begin
         if (w_clr) r_pending[wr_addr_i] <= 1'b0;
         if (set_en_i) begin
            r_pending[set_addr_i] <= 1'b1;
            r_ticket[set_addr_i]  <= set_ticket_i;
         end
      end
   end

   assign pend_a_o      = r_pending[lookup_a_i];
   assign ticket_a_o    = r_ticket[lookup_a_i];
   assign pend_b_o      = r_pending[lookup_b_i];
   assign ticket_b_o    = r_ticket[lookup_b_i];
   assign any_pending_o = |r_pending;

endmodule

`default_nettype wire

// File: rtl/vector_issue.sv
// ============================================================================
// vector_issue : single-entry vector issue stage with scoreboard and forwarding
// Rev 1.0
// ============================================================================
`default_nettype none

module vector_issue
   import vector_issue_pkg::*;
(
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic                                         uop_valid_i,
   input  to_vector_issue                               uop_i,
   output logic                                         uop_ready_o,
   output logic [REG_BITS-1:0]                          rf_addr_a_o,
   output logic [REG_BITS-1:0]                          rf_addr_b_o,
   input  logic [VECTOR_LANES-1:0][DATA_WIDTH-1:0]      rf_data_a_i,
   input  logic [VECTOR_LANES-1:0][DATA_WIDTH-1:0]      rf_data_b_i,
   output logic                                         valid_o,
   output to_vector_exec [VECTOR_LANES-1:0]             exec_data_o,
   output to_vector_exec_info                           exec_info_o,
   input  logic                                         ready_i,
   input  logic [VECTOR_LANES-1:0]                      frw_a_en_i,
   input  logic [REG_BITS-1:0]                          frw_a_addr_i,
   input  logic [VECTOR_LANES-1:0][DATA_WIDTH-1:0]      frw_a_data_i,
   input  logic [VECTOR_TICKET_BITS-1:0]                frw_a_ticket_i,
   input  logic [VECTOR_LANES-1:0]                      frw_b_en_i,
   input  logic [REG_BITS-1:0]                          frw_b_addr_i,
   input  logic [VECTOR_LANES-1:0][DATA_WIDTH-1:0]      frw_b_data_i,
   input  logic [VECTOR_TICKET_BITS-1:0]                frw_b_ticket_i,
   input  logic [VECTOR_LANES-1:0]                      wr_en_i,
   input  logic [REG_BITS-1:0]                          wr_addr_i,
   input  logic [VECTOR_LANES-1:0][DATA_WIDTH-1:0]      wr_data_i,
   input  logic [VECTOR_TICKET_BITS-1:0]                wr_ticket_i,
   output logic                                         issue_idle_o
);

   logic                                    r_held;
   to_vector_issue                          r_uop;
   logic                                    r_valid;
   to_vector_exec [VECTOR_LANES-1:0]        r_exec;
   to_vector_exec_info                      r_info;

   logic                                    w_pend1, w_pend2, w_any_pending;
   logic [VECTOR_TICKET_BITS-1:0]           w_sbt1, w_sbt2;
   logic                                    w_a1, w_b1, w_w1, w_a2, w_b2, w_w2;
   logic                                    w_ok1, w_ok2, w_fire;
   logic [VECTOR_LANES-1:0][DATA_WIDTH-1:0] w_op1, w_op2;

   vector_scoreboard u_sb (
      .clk           (clk),
      .rst_n         (rst_n),
      .set_en_i      (w_fire),
      .set_addr_i    (r_uop.dst),
      .set_ticket_i  (r_uop.ticket),
      .wr_en_i       (wr_en_i),
      .wr_addr_i     (wr_addr_i),
      .wr_ticket_i   (wr_ticket_i),
      .lookup_a_i    (r_uop.src1),
      .lookup_b_i    (r_uop.src2),
      .pend_a_o      (w_pend1),
      .ticket_a_o    (w_sbt1),
      .pend_b_o      (w_pend2),
      .ticket_b_o    (w_sbt2),
      .any_pending_o (w_any_pending)
   );

   assign w_a1 = w_pend1 & producer_hit(frw_a_en_i, frw_a_addr_i, frw_a_ticket_i, r_uop.src1, w_sbt1);
   assign w_b1 = w_pend1 & producer_hit(frw_b_en_i, frw_b_addr_i, frw_b_ticket_i, r_uop.src1, w_sbt1);
   assign w_w1 = w_pend1 & producer_hit(wr_en_i, wr_addr_i, wr_ticket_i, r_uop.src1, w_sbt1);
   assign w_a2 = w_pend2 & producer_hit(frw_a_en_i, frw_a_addr_i, frw_a_ticket_i, r_uop.src2, w_sbt2);
   assign w_b2 = w_pend2 & producer_hit(frw_b_en_i, frw_b_addr_i, frw_b_ticket_i, r_uop.src2, w_sbt2);
   assign w_w2 = w_pend2 & producer_hit(wr_en_i, wr_addr_i, wr_ticket_i, r_uop.src2, w_sbt2);

   assign w_ok1  = ~r_uop.use_src1 | ~w_pend1 | w_a1 | w_b1 | w_w1;
   assign w_ok2  = ~r_uop.use_src2 | ~w_pend2 | w_a2 | w_b2 | w_w2;
   assign w_fire = r_held & w_ok1 & w_ok2 & (~r_valid | ready_i);

   assign uop_ready_o  = ~r_held | w_fire;
   assign rf_addr_a_o  = r_uop.src1;
   assign rf_addr_b_o  = r_uop.src2;
   assign issue_idle_o = ~r_held & ~w_any_pending;

   // Later assignments take priority: forward A over B over writeback over the VRF.
   always_comb begin
      w_op1 = rf_data_a_i;
      w_op2 = rf_data_b_i;
      for (int k = 0; k < VECTOR_LANES; k++) begin
         if (w_w1 && wr_en_i[k])    w_op1[k] = wr_data_i[k];
         if (w_b1 && frw_b_en_i[k]) w_op1[k] = frw_b_data_i[k];
         if (w_a1 && frw_a_en_i[k]) w_op1[k] = frw_a_data_i[k];
         if (w_w2 && wr_en_i[k])    w_op2[k] = wr_data_i[k];
         if (w_b2 && frw_b_en_i[k]) w_op2[k] = frw_b_data_i[k];
         if (w_a2 && frw_a_en_i[k]) w_op2[k] = frw_a_data_i[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_held <= 1'b0;
         r_uop  <= '0;
      end else if (uop_valid_i && uop_ready_o) begin
         r_held <= 1'b1;
         r_uop  <= uop_i;
      end else if (w_fire) begin
         r_held <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_exec  <= '0;
         r_info  <= '0;
      end else if (w_fire) begin
         r_valid <= 1'b1;
         for (int k = 0; k < VECTOR_LANES; k++) begin
            r_exec[k].valid <= (VL_BITS'(k) < r_uop.vl);
            r_exec[k].mask  <= r_uop.mask[k];
            r_exec[k].data1 <= w_op1[k];
            r_exec[k].data2 <= w_op2[k];
         end
         r_info.dst      <= r_uop.dst;
         r_info.ticket   <= r_uop.ticket;
         r_info.funct6   <= r_uop.funct6;
         r_info.funct3   <= r_uop.funct3;
         r_info.vl       <= r_uop.vl;
         r_info.is_rdc   <= r_uop.is_rdc;
         r_info.head_uop <= r_uop.head_uop;
         r_info.end_uop  <= r_uop.end_uop;
      end else if (ready_i) begin
         r_valid <= 1'b0;
      end
   end

   assign valid_o     = r_valid;
   assign exec_data_o = r_exec;
   assign exec_info_o = r_info;

endmodule

`default_nettype wire

// File: tb/tb_vector_issue.sv
// ============================================================================
// tb_vector_issue : directed-vector bench for vector_issue
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vector_issue;
   import vector_issue_pkg::*;

   logic                                    clk = 1'b0;
   logic                                    rst_n;
   logic                                    uop_valid_i;
   to_vector_issue                          uop_i;
   logic                                    uop_ready_o;
   logic [REG_BITS-1:0]                     rf_addr_a_o, rf_addr_b_o;
   logic [VECTOR_LANES-1:0][DATA_WIDTH-1:0] rf_data_a_i, rf_data_b_i;
   logic                                    valid_o;
   to_vector_exec [VECTOR_LANES-1:0]        exec_data_o;
   to_vector_exec_info                      exec_info_o;
   logic                                    ready_i;
   logic [VECTOR_LANES-1:0]                 frw_a_en_i, frw_b_en_i, wr_en_i;
   logic [REG_BITS-1:0]                     frw_a_addr_i, frw_b_addr_i, wr_addr_i;
   logic [VECTOR_LANES-1:0][DATA_WIDTH-1:0] frw_a_data_i, frw_b_data_i, wr_data_i;
   logic [VECTOR_TICKET_BITS-1:0]           frw_a_ticket_i, frw_b_ticket_i, wr_ticket_i;
   logic                                    issue_idle_o;

   int n_vec = 0;
   int n_err = 0;

   vector_issue dut (
      .clk(clk), .rst_n(rst_n), .uop_valid_i(uop_valid_i), .uop_i(uop_i), .uop_ready_o(uop_ready_o),
      .rf_addr_a_o(rf_addr_a_o), .rf_addr_b_o(rf_addr_b_o),
      .rf_data_a_i(rf_data_a_i), .rf_data_b_i(rf_data_b_i),
      .valid_o(valid_o), .exec_data_o(exec_data_o), .exec_info_o(exec_info_o), .ready_i(ready_i),
      .frw_a_en_i(frw_a_en_i), .frw_a_addr_i(frw_a_addr_i), .frw_a_data_i(frw_a_data_i), .frw_a_ticket_i(frw_a_ticket_i),
      .frw_b_en_i(frw_b_en_i), .frw_b_addr_i(frw_b_addr_i), .frw_b_data_i(frw_b_data_i), .frw_b_ticket_i(frw_b_ticket_i),
      .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_ticket_i(wr_ticket_i),
      .issue_idle_o(issue_idle_o)
   );

   always #5 clk = ~clk;

   // Register-file model: every register/lane holds a distinct recognisable word.
   function automatic logic [31:0] rfval(input logic [4:0] r, input int k);
      return {8'h10, 3'b000, r, 8'h00, 8'(k)};
   endfunction

   always_comb begin
      for (int k = 0; k < VECTOR_LANES; k++) begin
         rf_data_a_i[k] = rfval(rf_addr_a_o, k);
         rf_data_b_i[k] = rfval(rf_addr_b_o, k);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_producers();
      frw_a_en_i = '0; frw_a_addr_i = '0; frw_a_data_i = '0; frw_a_ticket_i = '0;
      frw_b_en_i = '0; frw_b_addr_i = '0; frw_b_data_i = '0; frw_b_ticket_i = '0;
      wr_en_i = '0; wr_addr_i = '0; wr_data_i = '0; wr_ticket_i = '0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
   endtask

   task automatic drive_uop(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                            input logic [4:0] t, input logic [3:0] vl, input logic [7:0] m);
      uop_i          = '0;
      uop_i.src1     = s1;
      uop_i.src2     = s2;
      uop_i.dst      = d;
      uop_i.use_src1 = 1'b1;
      uop_i.use_src2 = 1'b1;
      uop_i.ticket   = t;
      uop_i.funct6   = 6'h15;
      uop_i.funct3   = 3'h2;
      uop_i.vl       = vl;
      uop_i.mask     = m;
      uop_i.end_uop  = 1'b1;
      uop_valid_i    = 1'b1;
   endtask

   task automatic test_reset();
      n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
      n_vec++; if (exec_data_o !== '0) begin n_err++; $display("FAIL reset_exec_data got=%h exp=0", exec_data_o); end
      n_vec++; if (exec_info_o !== '0) begin n_err++; $display("FAIL reset_exec_info got=%h exp=0", exec_info_o); end
      n_vec++; if (uop_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", uop_ready_o); end
      n_vec++; if (issue_idle_o !== 1'b1) begin n_err++; $display("FAIL reset_idle got=%b exp=1", issue_idle_o); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      drive_uop(5'd2, 5'd3, 5'd1, 5'd1, 4'd8, 8'hFF);
      step();
      drive_uop(5'd5, 5'd6, 5'd4, 5'd2, 4'd8, 8'hFF);
      step();
      uop_valid_i = 1'b0;
      n_vec++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL b2b_valid1 got=%b exp=1", valid_o); end
      n_vec++; if (exec_info_o.dst !== 5'd1) begin n_err++; $display("FAIL b2b_dst1 got=%0d exp=1", exec_info_o.dst); end
      n_vec++; if (exec_data_o[0].data1 !== rfval(5'd2, 0)) begin n_err++; $display("FAIL b2b_d1_l0 got=%h exp=%h", exec_data_o[0].data1, rfval(5'd2, 0)); end
      n_vec++; if (exec_data_o[7].data2 !== rfval(5'd3, 7)) begin n_err++; $display("FAIL b2b_d2_l7 got=%h exp=%h", exec_data_o[7].data2, rfval(5'd3, 7)); end
      step();
      n_vec++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL b2b_valid2 got=%b exp=1", valid_o); end
      n_vec++; if (exec_info_o.dst !== 5'd4 || exec_info_o.ticket !== 5'd2) begin n_err++; $display("FAIL b2b_info2 got=%0d/%0d exp=4/2", exec_info_o.dst, exec_info_o.ticket); end
      n_vec++; if (exec_data_o[3].data1 !== rfval(5'd5, 3)) begin n_err++; $display("FAIL b2b_d1_l3 got=%h exp=%h", exec_data_o[3].data1, rfval(5'd5, 3)); end
      n_vec++; if (dut.u_sb.r_pending[1] !== 1'b1 || dut.u_sb.r_pending[4] !== 1'b1) begin n_err++; $display("FAIL b2b_pending got=%b%b exp=11", dut.u_sb.r_pending[1], dut.u_sb.r_pending[4]); end
      n_vec++; if (issue_idle_o !== 1'b0) begin n_err++; $display("FAIL b2b_idle got=%b exp=0", issue_idle_o); end
   endtask

   // Producer v1 (ticket 3) issues, then v7<-v1,v2 is left stalled in the holding register.
   task automatic setup_raw_stall();
      do_reset();
      drive_uop(5'd2, 5'd3, 5'd1, 5'd3, 4'd8, 8'hFF);
      step();
      drive_uop(5'd1, 5'd2, 5'd7, 5'd5, 4'd8, 8'hFF);
      step();
      uop_valid_i = 1'b0;
      n_vec++; if (uop_ready_o !== 1'b0) begin n_err++; $display("FAIL raw_stall_ready got=%b exp=0", uop_ready_o); end
      step();
      n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL raw_stall_valid got=%b exp=0", valid_o); end
   endtask

   task automatic test_forward_b();
      setup_raw_stall();
      frw_b_en_i = 8'hFF; frw_b_addr_i = 5'd1; frw_b_ticket_i = 5'd3;
      for (int k = 0; k < VECTOR_LANES; k++) frw_b_data_i[k] = 32'hB000_0000 + k;
      step();
      clear_producers();
      n_vec++; if (valid_o !== 1'b1 || exec_info_o.dst !== 5'd7) begin n_err++; $display("FAIL fwdb_issue got=%b/%0d exp=1/7", valid_o, exec_info_o.dst); end
      n_vec++; if (exec_data_o[0].data1 !== 32'hB000_0000) begin n_err++; $display("FAIL fwdb_l0 got=%h exp=b0000000", exec_data_o[0].data1); end
      n_vec++; if (exec_data_o[7].data1 !== 32'hB000_0007) begin n_err++; $display("FAIL fwdb_l7 got=%h exp=b0000007", exec_data_o[7].data1); end
      n_vec++; if (exec_data_o[4].data2 !== rfval(5'd2, 4)) begin n_err++; $display("FAIL fwdb_src2 got=%h exp=%h", exec_data_o[4].data2, rfval(5'd2, 4)); end
   endtask

   task automatic test_stale_ticket();
      setup_raw_stall();
      frw_b_en_i = 8'hFF; frw_b_addr_i = 5'd1; frw_b_ticket_i = 5'd4; frw_b_data_i = '1;
      step();
      clear_producers();
      n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL stale_no_issue got=%b exp=0", valid_o); end
      wr_en_i = 8'hFF; wr_addr_i = 5'd1; wr_ticket_i = 5'd3;
      for (int k = 0; k < VECTOR_LANES; k++) wr_data_i[k] = 32'hC000_0000 + k;
      step();
      clear_producers();
      n_vec++; if (valid_o !== 1'b1 || exec_info_o.dst !== 5'd7) begin n_err++; $display("FAIL stale_wr_issue got=%b/%0d exp=1/7", valid_o, exec_info_o.dst); end
      n_vec++; if (exec_data_o[2].data1 !== 32'hC000_0002) begin n_err++; $display("FAIL stale_wr_data got=%h exp=c0000002", exec_data_o[2].data1); end
      n_vec++; if (dut.u_sb.r_pending[1] !== 1'b0) begin n_err++; $display("FAIL stale_clear got=%b exp=0", dut.u_sb.r_pending[1]); end
   endtask

   task automatic test_partial_forward();
      setup_raw_stall();
      frw_a_en_i = 8'h0F; frw_a_addr_i = 5'd1; frw_a_ticket_i = 5'd3;
      for (int k = 0; k < VECTOR_LANES; k++) frw_a_data_i[k] = 32'hA000_0000 + k;
      step();
      clear_producers();
      n_vec++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL part_issue got=%b exp=1", valid_o); end
      for (int k = 0; k < VECTOR_LANES; k++) begin
         logic [31:0] exp;
         exp = (k < 4) ? 32'hA000_0000 + k : rfval(5'd1, k);
         n_vec++; if (exec_data_o[k].data1 !== exp) begin n_err++; $display("FAIL part_lane%0d got=%h exp=%h", k, exec_data_o[k].data1, exp); end
      end
   endtask

   task automatic test_vl();
      logic [7:0] lv, lm;
      do_reset();
      drive_uop(5'd2, 5'd3, 5'd1, 5'd1, 4'd5, 8'hFF);
      step();
      uop_valid_i = 1'b0;
      step();
      for (int k = 0; k < VECTOR_LANES; k++) lv[k] = exec_data_o[k].valid;
      n_vec++; if (lv !== 8'h1F) begin n_err++; $display("FAIL vl5_lanes got=%h exp=1f", lv); end
      n_vec++; if (exec_info_o.vl !== 4'd5) begin n_err++; $display("FAIL vl5_info got=%0d exp=5", exec_info_o.vl); end
      drive_uop(5'd2, 5'd3, 5'd9, 5'd2, 4'd0, 8'h5A);
      step();
      uop_valid_i = 1'b0;
      step();
      for (int k = 0; k < VECTOR_LANES; k++) begin
         lv[k] = exec_data_o[k].valid;
         lm[k] = exec_data_o[k].mask;
      end
      n_vec++; if (valid_o !== 1'b1 || lv !== 8'h00) begin n_err++; $display("FAIL vl0_issue got=%b/%h exp=1/00", valid_o, lv); end
      n_vec++; if (lm !== 8'h5A) begin n_err++; $display("FAIL vl0_mask got=%h exp=5a", lm); end
      n_vec++; if (dut.u_sb.r_pending[9] !== 1'b1) begin n_err++; $display("FAIL vl0_pending got=%b exp=1", dut.u_sb.r_pending[9]); end
   endtask

   task automatic test_set_clear_same_cycle();
      do_reset();
      drive_uop(5'd2, 5'd3, 5'd1, 5'd3, 4'd8, 8'hFF);
      step();
      drive_uop(5'd2, 5'd3, 5'd1, 5'd6, 4'd8, 8'hFF);
      step();
      uop_valid_i = 1'b0;
      wr_en_i = 8'hFF; wr_addr_i = 5'd1; wr_ticket_i = 5'd3;
      step();
      clear_producers();
      n_vec++; if (dut.u_sb.r_pending[1] !== 1'b1) begin n_err++; $display("FAIL sc_pending got=%b exp=1", dut.u_sb.r_pending[1]); end
      n_vec++; if (dut.u_sb.r_ticket[1] !== 5'd6) begin n_err++; $display("FAIL sc_ticket got=%0d exp=6", dut.u_sb.r_ticket[1]); end
      n_vec++; if (issue_idle_o !== 1'b0) begin n_err++; $display("FAIL sc_idle got=%b exp=0", issue_idle_o); end
      wr_en_i = 8'h01; wr_addr_i = 5'd1; wr_ticket_i = 5'd6;
      step();
      clear_producers();
      n_vec++; if (dut.u_sb.r_pending[1] !== 1'b0) begin n_err++; $display("FAIL sc_clear got=%b exp=0", dut.u_sb.r_pending[1]); end
      n_vec++; if (issue_idle_o !== 1'b1) begin n_err++; $display("FAIL sc_idle_after got=%b exp=1", issue_idle_o); end
   endtask

   task automatic test_backpressure();
      do_reset();
      ready_i = 1'b0;
      drive_uop(5'd2, 5'd3, 5'd1, 5'd1, 4'd8, 8'hFF);
      step();
      drive_uop(5'd5, 5'd6, 5'd4, 5'd2, 4'd8, 8'hFF);
      step();
      uop_valid_i = 1'b0;
      step();
      n_vec++; if (valid_o !== 1'b1 || exec_info_o.dst !== 5'd1) begin n_err++; $display("FAIL bp_hold got=%b/%0d exp=1/1", valid_o, exec_info_o.dst); end
      n_vec++; if (exec_data_o[0].data1 !== rfval(5'd2, 0)) begin n_err++; $display("FAIL bp_payload got=%h exp=%h", exec_data_o[0].data1, rfval(5'd2, 0)); end
      n_vec++; if (uop_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_ready got=%b exp=0", uop_ready_o); end
      ready_i = 1'b1;
      step();
      n_vec++; if (valid_o !== 1'b1 || exec_info_o.dst !== 5'd4) begin n_err++; $display("FAIL bp_release got=%b/%0d exp=1/4", valid_o, exec_info_o.dst); end
   endtask

   task automatic test_reset_mid_stall();
      setup_raw_stall();
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if (uop_ready_o !== 1'b1 || issue_idle_o !== 1'b1) begin n_err++; $display("FAIL rst_stall got=%b/%b exp=1/1", uop_ready_o, issue_idle_o); end
      n_vec++; if (dut.u_sb.r_pending[1] !== 1'b0) begin n_err++; $display("FAIL rst_stall_sb got=%b exp=0", dut.u_sb.r_pending[1]); end
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n       = 1'b0;
      uop_valid_i = 1'b0;
      uop_i       = '0;
      ready_i     = 1'b1;
      clear_producers();
      #12 rst_n = 1'b1;
      step();
      test_reset();
      test_back_to_back();
      test_forward_b();
      test_stale_ticket();
      test_partial_forward();
      test_vl();
      test_set_clear_same_cycle();
      test_backpressure();
      test_reset_mid_stall();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
